mem_stage_wait: RTL

- Parametrised MIPS memory stage sitting between the EX/MEM and MEM/WB pipeline registers.
- Replaces the single-cycle data-memory path with a multi-cycle data memory that has a configurable wait count.
- Raises Freeze to hold the upstream pipeline while an access is in flight, and registers its results into the MEM/WB boundary.
- Adds address mapping with a configurable base, plus range, alignment and command checking with an error flag.

---
 rtl/mem_stage_wait.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_wait.sv
// MIPS memory stage with a multi-cycle data memory.
// A memory command freezes the upstream pipeline for WAIT_CYCLES cycles and then
// commits in a single cycle, where the store is performed or the load data is
// registered into the MEM/WB boundary. Out-of-range, misaligned or illegal
// commands are suppressed and flagged with a one-cycle Addr_Err pulse, but they
// keep the same timing as a legal access.
module mem_stage_wait #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3,
    parameter int DST_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN_MEM,
    input  logic [1:0]            MEM_CMD_MEM,
    input  logic [DATA_WIDTH-1:0] Alu_result_MEM,
    input  logic [DATA_WIDTH-1:0] Src2_Val_MEM,
    input  logic [DST_WIDTH-1:0]  DST_MEM,
    output logic                  Freeze,
    output logic                  WB_EN_WB,
    output logic                  MEM_R_EN_WB,
    output logic [DATA_WIDTH-1:0] Alu_result_WB,
    output logic [DATA_WIDTH-1:0] Data_Mem_WB,
    output logic [DST_WIDTH-1:0]  DST_WB,
    output logic                  Addr_Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [DATA_WIDTH-1:0] BASE     = DATA_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]         CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wb_en_q, wb_en_d;
    logic                    mem_r_en_q, mem_r_en_d;
    logic [DATA_WIDTH-1:0]   alu_q, alu_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DST_WIDTH-1:0]    dst_q, dst_d;
    logic                    err_q, err_d;

    logic                    mem_cmd;
    logic [DATA_WIDTH-1:0]   offset;
    logic [AW-1:0]           idx;
    logic                    bad;
    logic                    commit;
    logic                    freeze;

    // Address decode and access legality; the underflow test compares the raw
    // address so that the wrapped offset cannot hide an access below the base.
    always_comb begin
        mem_cmd = |MEM_CMD_MEM;
        offset  = Alu_result_MEM - BASE;
        idx     = offset[AW+1:2];
        bad     = mem_cmd && ((Alu_result_MEM < BASE)
                              || (|offset[DATA_WIDTH-1:AW+2])
                              || (|offset[1:0])
                              || (MEM_CMD_MEM == CMD_ILL));
        commit  = mem_cmd && ((state_q == S_COMMIT)
                              || (state_q == S_IDLE && WAIT_CYCLES == 0));
        // Reset forces Freeze low at once, even if upstream still presents a command.
        freeze  = !rst && ((state_q == S_IDLE && mem_cmd && WAIT_CYCLES > 0)
                           || state_q == S_WAIT);
    end

    // Next-state logic for the access sequencer and its wait counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_cmd && WAIT_CYCLES > 0) begin
                    cnt_d = CNT_LOAD;
                    // A single wait cycle is spent in IDLE itself, so go straight to commit.
                    state_d = (WAIT_CYCLES == 1) ? S_COMMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // MEM/WB next values: bubble while frozen, otherwise capture the instruction.
    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_d      = alu_q;
        data_d     = data_q;
        dst_d      = dst_q;
        err_d      = 1'b0;
        if (freeze) begin
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
        end else begin
            wb_en_d    = WB_EN_MEM;
            mem_r_en_d = MEM_CMD_MEM[0];
            alu_d      = Alu_result_MEM;
            dst_d      = DST_MEM;
            data_d     = (commit && MEM_CMD_MEM == CMD_RD && !bad) ? mem_q[idx] : '0;
            err_d      = commit && bad;
        end
    end

    // Sequencer state and MEM/WB pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_q      <= '0;
            data_q     <= '0;
            dst_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_q      <= alu_d;
            data_q     <= data_d;
            dst_q      <= dst_d;
            err_q      <= err_d;
        end
    end

    // Data memory: written only by a legal store in its commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the memory is cleared on reset on purpose, which forces a register
            // array rather than a RAM macro; keep DEPTH small.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && MEM_CMD_MEM == CMD_WR && !bad) begin
            mem_q[idx] <= Src2_Val_MEM;
        end
    end

    assign Freeze        = freeze;
    assign WB_EN_WB      = wb_en_q;
    assign MEM_R_EN_WB   = mem_r_en_q;
    assign Alu_result_WB = alu_q;
    assign Data_Mem_WB   = data_q;
    assign DST_WB        = dst_q;
    assign Addr_Err      = err_q;

endmodule
